// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/shift/add/sub, shift-add multiply, registered result slot
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic [4:0]           flags,
    output logic                 busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ADD = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     out_q, out_d;
    logic [4:0]             flags_q, flags_d;
    logic                   out_valid_q, out_valid_d;
    logic [SHW-1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;

    logic                   accept;
    logic [SHW-1:0]         sh;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;
    logic [WIDTH-1:0]       rot;
    logic [2*WIDTH-1:0]     sc_res;
    logic                   sc_carry;
    logic                   sc_ovf;
    logic                   sc_err;
    logic [4:0]             sc_flags;
    logic [2*WIDTH-1:0]     mul_acc_next;
    logic [4:0]             mul_flags;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_MUL);

    assign sh   = b[SHW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign rot  = WIDTH'({a, a} >> sh);

    // Single-cycle result and flags; MUL is handled by the sequencer below.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (op)
            OP_NOT: sc_res = {{WIDTH{1'b0}}, ~a};
            OP_OR:  sc_res = {{WIDTH{1'b0}}, a | b};
            OP_AND: sc_res = {{WIDTH{1'b0}}, a & b};
            OP_NOR: sc_res = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XOR: sc_res = {{WIDTH{1'b0}}, a ^ b};
            OP_ASL: sc_res = {{WIDTH{1'b0}}, a} << sh;
            OP_ROR: sc_res = {{WIDTH{1'b0}}, rot};
            OP_ADD: begin
                sc_res   = {{(WIDTH-1){1'b0}}, sum};
                sc_carry = sum[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Upper half replicates the borrow so the 2W result reads as signed.
                sc_res   = {{WIDTH{diff[WIDTH]}}, diff[WIDTH-1:0]};
                sc_carry = diff[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: sc_res = '0;
            default: sc_err = 1'b1;
        endcase
        sc_flags = {sc_err, sc_res[2*WIDTH-1], sc_ovf, sc_carry, (sc_res == '0)};
    end

    assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_flags    = {1'b0, mul_acc_next[2*WIDTH-1], 1'b0, 1'b0, (mul_acc_next == '0)};

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        out_d       = sc_res;
                        flags_d     = sc_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    out_d       = mul_acc_next;
                    flags_d     = mul_flags;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq at WIDTH 8, 16 and 32
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  op;
    logic        out_ready;

    logic        iv8, ir8, ov8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;
    logic [4:0]  f8;

    logic        iv16, ir16, ov16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] o16;
    logic [4:0]  f16;

    logic        iv32, ir32, ov32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] o32;
    logic [4:0]  f32;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op),
        .out_valid(ov8), .out_ready(out_ready), .out(o8), .flags(f8), .busy(busy8)
    );
    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .op(op),
        .out_valid(ov16), .out_ready(out_ready), .out(o16), .flags(f16), .busy(busy16)
    );
    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .op(op),
        .out_valid(ov32), .out_ready(out_ready), .out(o32), .flags(f32), .busy(busy32)
    );

    typedef struct {
        int          w;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] out;
        logic [4:0]  flags;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int w, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                           input logic [63:0] eo, input logic [4:0] ef, input string n);
        vec_t v;
        v.w = w; v.op = o; v.a = va; v.b = vb; v.out = eo; v.flags = ef; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] ao;
        logic [4:0]  af;
        logic        av;
        iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
        op = v.op;
        case (v.w)
            8:       begin a8  = v.a[7:0];  b8  = v.b[7:0];  iv8  = 1'b1; end
            16:      begin a16 = v.a[15:0]; b16 = v.b[15:0]; iv16 = 1'b1; end
            default: begin a32 = v.a;       b32 = v.b;       iv32 = 1'b1; end
        endcase
        @(posedge clk); #1;
        case (v.w)
            8:       begin ao = {48'd0, o8};  af = f8;  av = ov8;  end
            16:      begin ao = {32'd0, o16}; af = f16; av = ov16; end
            default: begin ao = o32;          af = f32; av = ov32; end
        endcase
        check({v.name, "_valid"}, {63'd0, av}, 64'd1);
        check({v.name, "_out"}, ao, v.out);
        check({v.name, "_flags"}, {59'd0, af}, {59'd0, v.flags});
    endtask

    task automatic do_mul16(input logic [15:0] ma, input logic [15:0] mb,
                            input logic [31:0] exp, input logic [4:0] expf, input string name);
        int lat;
        bit bad;
        iv16 = 1'b1; a16 = ma; b16 = mb; op = 4'd9;
        @(posedge clk); #1;
        // A competing ADD request with different operands sits on the inputs for the whole MUL.
        op = 4'd7; a16 = 16'd1; b16 = 16'd1;
        lat = 0;
        bad = 1'b0;
        while (!ov16 && lat < 40) begin
            if (ir16 || !busy16) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        iv16 = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'd16);
        check({name, "_busy_noready"}, {63'd0, bad}, 64'd0);
        check({name, "_out"}, {32'd0, o16}, {32'd0, exp});
        check({name, "_flags"}, {59'd0, f16}, {59'd0, expf});
        check({name, "_busy_fall"}, {63'd0, busy16}, 64'd0);
        @(posedge clk); #1;
        check({name, "_no_extra"}, {63'd0, ov16}, 64'd0);
        check({name, "_hold"}, {32'd0, o16}, {32'd0, exp});
    endtask

    initial begin
        int cnt;
        bit moved;

        rst_n = 1'b0; out_ready = 1'b1; op = 4'd0;
        iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;

        // WIDTH=16: logic ops back-to-back, then arithmetic, shift/rotate, illegal
        add_vec(16, 4'd0, 32'd14, 32'd12, 64'h0000FFF1, 5'b00000, "w16_not");
        add_vec(16, 4'd1, 32'd14, 32'd12, 64'h0000000E, 5'b00000, "w16_or");
        add_vec(16, 4'd2, 32'd14, 32'd12, 64'h0000000C, 5'b00000, "w16_and");
        add_vec(16, 4'd3, 32'd14, 32'd12, 64'h0000FFF1, 5'b00000, "w16_nor");
        add_vec(16, 4'd4, 32'd14, 32'd12, 64'h00000002, 5'b00000, "w16_xor");
        add_vec(16, 4'd7, 32'hFFFF, 32'h1, 64'h00010000, 5'b00010, "w16_add_carry");
        add_vec(16, 4'd7, 32'h7FFF, 32'h1, 64'h00008000, 5'b00100, "w16_add_ovf");
        add_vec(16, 4'd8, 32'd12, 32'd14, 64'hFFFFFFFE, 5'b01010, "w16_sub_borrow");
        add_vec(16, 4'd8, 32'd5, 32'd5, 64'h00000000, 5'b00001, "w16_sub_zero");
        add_vec(16, 4'd5, 32'd14, 32'd12, 64'h0000E000, 5'b00000, "w16_asl");
        add_vec(16, 4'd5, 32'hFFFF, 32'd15, 64'h7FFF8000, 5'b00000, "w16_asl_wide");
        add_vec(16, 4'd6, 32'd14, 32'd1, 64'h00000007, 5'b00000, "w16_ror");
        add_vec(16, 4'd6, 32'd1, 32'd17, 64'h00008000, 5'b00000, "w16_ror_mod");
        add_vec(16, 4'd15, 32'd14, 32'd12, 64'h00000000, 5'b10001, "w16_illegal");
        // WIDTH=8
        add_vec(8, 4'd0, 32'd14, 32'd12, 64'h00F1, 5'b00000, "w8_not");
        add_vec(8, 4'd1, 32'd14, 32'd12, 64'h000E, 5'b00000, "w8_or");
        add_vec(8, 4'd2, 32'd14, 32'd12, 64'h000C, 5'b00000, "w8_and");
        add_vec(8, 4'd3, 32'd14, 32'd12, 64'h00F1, 5'b00000, "w8_nor");
        add_vec(8, 4'd4, 32'd14, 32'd12, 64'h0002, 5'b00000, "w8_xor");
        add_vec(8, 4'd7, 32'hFF, 32'h1, 64'h0100, 5'b00010, "w8_add_carry");
        add_vec(8, 4'd7, 32'h7F, 32'h1, 64'h0080, 5'b00100, "w8_add_ovf");
        add_vec(8, 4'd8, 32'd12, 32'd14, 64'hFFFE, 5'b01010, "w8_sub_borrow");
        add_vec(8, 4'd5, 32'd14, 32'd12, 64'h00E0, 5'b00000, "w8_asl_mod");
        add_vec(8, 4'd6, 32'd14, 32'd1, 64'h0007, 5'b00000, "w8_ror");
        add_vec(8, 4'd6, 32'd1, 32'd9, 64'h0080, 5'b00000, "w8_ror_mod");
        // WIDTH=32
        add_vec(32, 4'd0, 32'd14, 32'd12, 64'h00000000FFFFFFF1, 5'b00000, "w32_not");
        add_vec(32, 4'd1, 32'd14, 32'd12, 64'h000000000000000E, 5'b00000, "w32_or");
        add_vec(32, 4'd2, 32'd14, 32'd12, 64'h000000000000000C, 5'b00000, "w32_and");
        add_vec(32, 4'd3, 32'd14, 32'd12, 64'h00000000FFFFFFF1, 5'b00000, "w32_nor");
        add_vec(32, 4'd4, 32'd14, 32'd12, 64'h0000000000000002, 5'b00000, "w32_xor");
        add_vec(32, 4'd7, 32'hFFFFFFFF, 32'h1, 64'h0000000100000000, 5'b00010, "w32_add_carry");
        add_vec(32, 4'd7, 32'h7FFFFFFF, 32'h1, 64'h0000000080000000, 5'b00100, "w32_add_ovf");
        add_vec(32, 4'd8, 32'd12, 32'd14, 64'hFFFFFFFFFFFFFFFE, 5'b01010, "w32_sub_borrow");
        add_vec(32, 4'd5, 32'd14, 32'd12, 64'h000000000000E000, 5'b00000, "w32_asl");
        add_vec(32, 4'd5, 32'hFFFFFFFF, 32'd31, 64'h7FFFFFFF80000000, 5'b00000, "w32_asl_wide");
        add_vec(32, 4'd6, 32'd14, 32'd1, 64'h0000000000000007, 5'b00000, "w32_ror");
        add_vec(32, 4'd6, 32'd1, 32'd33, 64'h0000000080000000, 5'b00000, "w32_ror_mod");

        repeat (2) @(posedge clk);
        #1;
        check("rst_out16", {32'd0, o16}, 64'd0);
        check("rst_flags16", {59'd0, f16}, 64'd0);
        check("rst_valid_busy", {60'd0, ov8, ov16, ov32, busy16}, 64'd0);
        check("rst_ready", {61'd0, ir8, ir16, ir32}, 64'd7);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // in_valid stays high across consecutive vectors, so each one is a back-to-back issue
        foreach (vecs[i]) run_vec(vecs[i]);
        iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
        @(posedge clk); #1;

        do_mul16(16'd14, 16'd12, 32'h000000A8, 5'b00000, "mul_14x12");
        do_mul16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'b01000, "mul_ffff");

        // Backpressure: result held, next request waits until out_ready returns
        out_ready = 1'b0;
        iv16 = 1'b1; op = 4'd7; a16 = 16'd3; b16 = 16'd4;
        @(posedge clk); #1;
        op = 4'd8; a16 = 16'd9; b16 = 16'd4;
        moved = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (ir16 || !ov16 || o16 != 32'd7 || f16 != 5'd0) moved = 1'b1;
            @(posedge clk); #1;
        end
        check("bp_stable", {63'd0, moved}, 64'd0);
        check("bp_out", {32'd0, o16}, 64'd7);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", {63'd0, ir16}, 64'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        check("bp_next_out", {32'd0, o16}, 64'd5);
        check("bp_next_valid", {63'd0, ov16}, 64'd1);
        @(posedge clk); #1;

        // Reset on the 8th MUL cycle aborts the multiply
        iv16 = 1'b1; op = 4'd9; a16 = 16'd14; b16 = 16'd12;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out", {32'd0, o16}, 64'd0);
        check("abort_flags", {59'd0, f16}, 64'd0);
        check("abort_valid_busy", {62'd0, ov16, busy16}, 64'd0);
        check("abort_ready", {63'd0, ir16}, 64'd1);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ov16) cnt++;
        end
        check("abort_no_late", 64'(cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
